soc_msp430_noc_packet_arbiter: RTL

SOC_MSP430_NOC_PACKET_ARBITER -- requirements
Module: soc_msp430_noc_packet_arbiter

---
 rtl/soc_msp430_noc_packet_arbiter_if.sv | 29 ++
 rtl/soc_msp430_noc_packet_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/soc_msp430_noc_packet_arbiter_if.sv
// Requester/NoC channel bundle for the packet arbiter.
// The slave modport is the arbiter side; the master modport is the requesters plus the NoC sink.
interface soc_msp430_noc_packet_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int FLIT_WIDTH = 32
);
  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [FLIT_WIDTH-1:0]         out_flit;
  logic                          out_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          err_overlong;
  logic [15:0]                   pkt_count;

  modport master (
    output req_flit, req_last, req_valid, out_ready,
    input  req_ready, out_flit, out_last, out_valid, grant, busy, err_overlong, pkt_count
  );

  modport slave (
    input  req_flit, req_last, req_valid, out_ready,
    output req_ready, out_flit, out_last, out_valid, grant, busy, err_overlong, pkt_count
  );
endinterface

// File: rtl/soc_msp430_noc_packet_arbiter.sv
// Round-robin packet arbiter: locks the NoC output channel to one requester from the
// first flit of a packet until its last flit, with a zero-bubble grant from IDLE.
module soc_msp430_noc_packet_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int FLIT_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 12
) (
  input logic clk,
  input logic rst,
  soc_msp430_noc_packet_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_reg;
  logic [CW-1:0]   flit_cnt;
  logic [15:0]     pkt_count;
  logic            err_overlong;

  logic [IW-1:0]   sel;
  logic [IW-1:0]   cur;
  logic            found;
  logic            any_valid;
  logic            active;
  logic            flit_valid;
  logic            flit_last;
  logic            xfer;
  logic [NUM_REQ-1:0] cur_onehot;
  logic [CW-1:0]   cnt_inc;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Circular search for the first valid requester at or after rr_ptr.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        sel   = IW'((int'(rr_ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  assign any_valid  = |bus.req_valid;
  assign cur        = (state == LOCKED) ? gnt_reg : sel;
  assign active     = !rst && ((state == LOCKED) || any_valid);
  assign cur_onehot = NUM_REQ'(1) << cur;
  assign flit_valid = active && bus.req_valid[cur];
  assign flit_last  = bus.req_last[cur];
  assign xfer       = flit_valid && bus.out_ready;
  assign cnt_inc    = (flit_cnt < CW'(MAX_PKT_LEN)) ? flit_cnt + 1'b1 : flit_cnt;

  assign bus.out_flit     = bus.req_flit[int'(cur)*FLIT_WIDTH +: FLIT_WIDTH];
  assign bus.out_last     = flit_last;
  assign bus.out_valid    = flit_valid;
  assign bus.grant        = active ? cur_onehot : '0;
  assign bus.req_ready    = (active && bus.out_ready) ? cur_onehot : '0;
  assign bus.busy         = !rst && (state == LOCKED);
  assign bus.pkt_count    = pkt_count;
  assign bus.err_overlong = err_overlong;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_reg      <= '0;
      flit_cnt     <= '0;
      pkt_count    <= '0;
      err_overlong <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            if (xfer && flit_last) begin
              rr_ptr    <= next_idx(sel);
              pkt_count <= pkt_count + 16'd1;
            end else begin
              state    <= LOCKED;
              gnt_reg  <= sel;
              flit_cnt <= xfer ? CW'(1) : '0;
            end
          end
        end
        LOCKED: begin
          if (xfer) begin
            if (flit_last) begin
              state     <= IDLE;
              rr_ptr    <= next_idx(gnt_reg);
              pkt_count <= pkt_count + 16'd1;
              flit_cnt  <= '0;
            end else begin
              flit_cnt <= cnt_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // flit_cnt is zero in IDLE, so this also covers a packet's first flit.
      if (xfer && !flit_last && (flit_cnt >= CW'(MAX_PKT_LEN - 1)))
        err_overlong <= 1'b1;
    end
  end
endmodule
